// File: rtl/p405s_timerwdctl_if.sv
// Signal bundle between the p405s timer watchdog/FIT controller and its surroundings.
// The master side drives pulses, enables and SPR writes; the slave side returns status and resets.
interface p405s_timerwdctl_if;
    logic       wdPulse;
    logic       fitPulse;
    logic       wdIntrpEn;
    logic       fitIntrpEn;
    logic       wrcWrEn;
    logic [0:1] wrcWrData;
    logic       tsrClrEn;
    logic [0:2] tsrClrData;
    logic       tsrEnw;
    logic       tsrWis;
    logic       tsrFis;
    logic [0:1] tcrWrc;
    logic       wdIntrp;
    logic       fitIntrp;
    logic       enableNxtWdTic;
    logic       TIM_wdCoreRst;
    logic       TIM_wdChipRst;
    logic       TIM_wdSysRst;

    modport master (
        output wdPulse, fitPulse, wdIntrpEn, fitIntrpEn,
        output wrcWrEn, wrcWrData, tsrClrEn, tsrClrData,
        input  tsrEnw, tsrWis, tsrFis, tcrWrc, wdIntrp, fitIntrp,
        input  enableNxtWdTic, TIM_wdCoreRst, TIM_wdChipRst, TIM_wdSysRst
    );

    modport slave (
        input  wdPulse, fitPulse, wdIntrpEn, fitIntrpEn,
        input  wrcWrEn, wrcWrData, tsrClrEn, tsrClrData,
        output tsrEnw, tsrWis, tsrFis, tcrWrc, wdIntrp, fitIntrp,
        output enableNxtWdTic, TIM_wdCoreRst, TIM_wdChipRst, TIM_wdSysRst
    );
endinterface

// File: rtl/p405s_timerwdctl.sv
// Watchdog {ENW,WIS} sequencer, FIT status, sticky TCR[WRC] and the held watchdog reset request.
// Watchdog resets stay asserted from the expiring pulse until timResetL returns low.
module p405s_timerwdctl (
    input  logic                   CB,
    input  logic                   timResetL,
    p405s_timerwdctl_if.slave      tim
);
    localparam int unsigned WrcW = 2;
    localparam int unsigned ClrW = 3;

    typedef enum logic {RST_IDLE, RST_ACT} rstStateT;

    localparam logic [0:WrcW-1] WrcNone = WrcW'(0);
    localparam logic [0:WrcW-1] WrcCore = WrcW'(1);
    localparam logic [0:WrcW-1] WrcChip = WrcW'(2);
    localparam logic [0:WrcW-1] WrcSys  = WrcW'(3);

    rstStateT        rstState, rstStateNxt;
    logic            enw, enwNxt;
    logic            wis, wisNxt;
    logic            fis, fisNxt;
    logic [0:WrcW-1] wrc, wrcNxt;
    logic            coreRst, coreRstNxt;
    logic            chipRst, chipRstNxt;
    logic            sysRst, sysRstNxt;
    logic            enableTic_c;
    logic            qualPulse_c;
    logic            enwHwSet_c;
    logic            wisHwSet_c;
    logic [0:ClrW-1] clrMask_c;

    // State register; reset wins over every same-cycle input
    always_ff @(posedge CB) begin
        if (!timResetL) begin
            rstState <= RST_IDLE;
            enw      <= 1'b0;
            wis      <= 1'b0;
            fis      <= 1'b0;
            wrc      <= WrcNone;
            coreRst  <= 1'b0;
            chipRst  <= 1'b0;
            sysRst   <= 1'b0;
        end else begin
            rstState <= rstStateNxt;
            enw      <= enwNxt;
            wis      <= wisNxt;
            fis      <= fisNxt;
            wrc      <= wrcNxt;
            coreRst  <= coreRstNxt;
            chipRst  <= chipRstNxt;
            sysRst   <= sysRstNxt;
        end
    end

    // Next-state: hardware sets take priority over software write-1-to-clear
    always_comb begin
        rstStateNxt = rstState;
        enwNxt      = enw;
        wisNxt      = wis;
        fisNxt      = fis;
        wrcNxt      = wrc;
        coreRstNxt  = 1'b0;
        chipRstNxt  = 1'b0;
        sysRstNxt   = 1'b0;

        enableTic_c = (rstState == RST_IDLE);
        qualPulse_c = tim.wdPulse & enableTic_c;
        clrMask_c   = tim.tsrClrEn ? tim.tsrClrData : ClrW'(0);

        // ENW is driven to 1 by any pulse below state 11; WIS only by the 10 -> 11 step
        enwHwSet_c  = qualPulse_c & ~(enw & wis);
        wisHwSet_c  = qualPulse_c & enw & ~wis;

        enwNxt = enwHwSet_c    | (enw & ~clrMask_c[0]);
        wisNxt = wisHwSet_c    | (wis & ~clrMask_c[1]);
        fisNxt = tim.fitPulse  | (fis & ~clrMask_c[2]);

        if (tim.wrcWrEn && (wrc == WrcNone)) begin
            wrcNxt = tim.wrcWrData;
        end

        if (qualPulse_c && enw && wis && (wrc != WrcNone)) begin
            rstStateNxt = RST_ACT;
        end

        // WRC is already nonzero and frozen whenever the FSM is (or becomes) active
        if (rstStateNxt == RST_ACT) begin
            coreRstNxt = (wrc == WrcCore);
            chipRstNxt = (wrc == WrcChip);
            sysRstNxt  = (wrc == WrcSys);
        end
    end

    assign tim.tsrEnw         = enw;
    assign tim.tsrWis         = wis;
    assign tim.tsrFis         = fis;
    assign tim.tcrWrc         = wrc;
    assign tim.wdIntrp        = wis & tim.wdIntrpEn;
    assign tim.fitIntrp       = fis & tim.fitIntrpEn;
    assign tim.enableNxtWdTic = (rstState == RST_IDLE);
    assign tim.TIM_wdCoreRst  = coreRst;
    assign tim.TIM_wdChipRst  = chipRst;
    assign tim.TIM_wdSysRst   = sysRst;
endmodule
